// File: rtl/ex_stage.sv
// ex_stage : execute stage of the 5-stage RV32I pipeline.
//
// Resolves rs1/rs2 forwarding (EX/MEM first, then WB), runs the ALU, resolves
// branches/jumps toward fetch, and owns the EX/MEM pipeline register.
//
// Optional feature macro: RV32M_MUL_EN
//   defined   : 33-cycle iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU,
//               asserting ex_busy while it occupies EX.
//   undefined : ops 11..14 produce 0 in a single cycle, ex_busy tied low.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-high reset
//   valid_in..regwr_in  ID/EX register contents
//   wb_*_in             writeback-stage forwarding source
//   stall_in            memory stage stalled: hold EX/MEM
//   ex_busy             multiplier occupies EX (combinational)
//   branch_taken/target fetch redirect (combinational)
//   *_out               EX/MEM register
module ex_stage #(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [BIT_W-1:0] pc_in,
  input  logic [BIT_W-1:0] rs1_data_in,
  input  logic [BIT_W-1:0] rs2_data_in,
  input  logic [BIT_W-1:0] imm_in,
  input  logic [4:0]       rs1_in,
  input  logic [4:0]       rs2_in,
  input  logic [4:0]       rd_in,
  input  logic [3:0]       alu_op_in,
  input  logic             alu_src_pc_in,
  input  logic             alu_src_imm_in,
  input  logic             branch_in,
  input  logic             jal_in,
  input  logic             jalr_in,
  input  logic [2:0]       funct3_in,
  input  logic             memrd_in,
  input  logic             memwr_in,
  input  logic             mem2reg_in,
  input  logic             regwr_in,
  input  logic             wb_regwr_in,
  input  logic [4:0]       wb_rd_in,
  input  logic [BIT_W-1:0] wb_data_in,
  input  logic             stall_in,
  output logic             ex_busy,
  output logic             branch_taken,
  output logic [BIT_W-1:0] branch_target,
  output logic [BIT_W-1:0] alu_result_out,
  output logic [BIT_W-1:0] mem_wdata_out,
  output logic [BIT_W-1:0] PC_plus_4_out,
  output logic [4:0]       rd_out,
  output logic             memrd_out,
  output logic             memwr_out,
  output logic             mem2reg_out,
  output logic             regwr_out
);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_SLL    = 4'd2;
  localparam logic [3:0] OP_SLT    = 4'd3;
  localparam logic [3:0] OP_SLTU   = 4'd4;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_SRL    = 4'd6;
  localparam logic [3:0] OP_SRA    = 4'd7;
  localparam logic [3:0] OP_OR     = 4'd8;
  localparam logic [3:0] OP_AND    = 4'd9;
  localparam logic [3:0] OP_PASSB  = 4'd10;
  localparam logic [3:0] OP_MUL    = 4'd11;
  localparam logic [3:0] OP_MULH   = 4'd12;
  localparam logic [3:0] OP_MULHSU = 4'd13;
  localparam logic [3:0] OP_MULHU  = 4'd14;

  logic [BIT_W-1:0] fwd_rs1_s, fwd_rs2_s, op_a_s, op_b_s;
  logic [BIT_W-1:0] alu_s, result_s, mul_res_s;
  logic [4:0]       shamt_s;
  logic             cond_s, ex_busy_s;

  // Operand forwarding: EX/MEM has priority over WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1_s = rs1_data_in;
    fwd_rs2_s = rs2_data_in;
    if (rs1_in != 5'd0 && regwr_out && rd_out == rs1_in) begin
      fwd_rs1_s = alu_result_out;
    end else if (rs1_in != 5'd0 && wb_regwr_in && wb_rd_in == rs1_in) begin
      fwd_rs1_s = wb_data_in;
    end else begin
      fwd_rs1_s = rs1_data_in;
    end
    if (rs2_in != 5'd0 && regwr_out && rd_out == rs2_in) begin
      fwd_rs2_s = alu_result_out;
    end else if (rs2_in != 5'd0 && wb_regwr_in && wb_rd_in == rs2_in) begin
      fwd_rs2_s = wb_data_in;
    end else begin
      fwd_rs2_s = rs2_data_in;
    end
  end

  assign op_a_s  = alu_src_pc_in  ? pc_in  : fwd_rs1_s;
  assign op_b_s  = alu_src_imm_in ? imm_in : fwd_rs2_s;
  assign shamt_s = op_b_s[4:0];

  // ALU operation select; multiply ops take the multiplier's result.
  always_comb begin
    alu_s = {BIT_W{1'b0}};
    case (alu_op_in)
      OP_ADD:    alu_s = op_a_s + op_b_s;
      OP_SUB:    alu_s = op_a_s - op_b_s;
      OP_SLL:    alu_s = op_a_s << shamt_s;
      OP_SLT:    alu_s = {{(BIT_W-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
      OP_SLTU:   alu_s = {{(BIT_W-1){1'b0}}, (op_a_s < op_b_s)};
      OP_XOR:    alu_s = op_a_s ^ op_b_s;
      OP_SRL:    alu_s = op_a_s >> shamt_s;
      OP_SRA:    alu_s = $signed(op_a_s) >>> shamt_s;
      OP_OR:     alu_s = op_a_s | op_b_s;
      OP_AND:    alu_s = op_a_s & op_b_s;
      OP_PASSB:  alu_s = op_b_s;
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: alu_s = mul_res_s;
      default:   alu_s = {BIT_W{1'b0}};
    endcase
  end

  // Jumps write the link address regardless of the ALU op.
  assign result_s = (jal_in | jalr_in) ? (pc_in + 32'd4) : alu_s;

  // Branch condition on forwarded register values.
  always_comb begin
    cond_s = 1'b0;
    case (funct3_in)
      3'b000:  cond_s = (fwd_rs1_s == fwd_rs2_s);
      3'b001:  cond_s = (fwd_rs1_s != fwd_rs2_s);
      3'b100:  cond_s = ($signed(fwd_rs1_s) <  $signed(fwd_rs2_s));
      3'b101:  cond_s = ($signed(fwd_rs1_s) >= $signed(fwd_rs2_s));
      3'b110:  cond_s = (fwd_rs1_s <  fwd_rs2_s);
      3'b111:  cond_s = (fwd_rs1_s >= fwd_rs2_s);
      default: cond_s = 1'b0;
    endcase
  end

  assign branch_taken  = valid_in & ~stall_in & ~ex_busy_s &
                         (jal_in | jalr_in | (branch_in & cond_s));
  assign branch_target = jalr_in ? ((fwd_rs1_s + imm_in) & {{(BIT_W-1){1'b1}}, 1'b0})
                                 : (pc_in + imm_in);
  assign ex_busy       = ex_busy_s;

`ifdef RV32M_MUL_EN
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  mul_state_t  mul_state_r, mul_state_nxt_s;
  logic        mul_start_s, mul_a_signed_s, mul_b_signed_s;
  logic [65:0] acc_r, mcand_r, mcand_init_s;
  logic [31:0] mplier_r;
  logic [4:0]  count_r;
  logic [1:0]  unused_acc_hi_s;

  assign mul_start_s    = (mul_state_r == MUL_IDLE) & valid_in &
                          (alu_op_in >= OP_MUL) & (alu_op_in <= OP_MULHU);
  assign mul_a_signed_s = (alu_op_in == OP_MULH) | (alu_op_in == OP_MULHSU);
  assign mul_b_signed_s = (alu_op_in == OP_MULH);
  assign mcand_init_s   = mul_a_signed_s ? {{34{fwd_rs1_s[31]}}, fwd_rs1_s}
                                         : {34'd0, fwd_rs1_s};
  assign ex_busy_s      = mul_start_s | (mul_state_r == MUL_BUSY);
  assign mul_res_s      = (alu_op_in == OP_MUL) ? acc_r[31:0] : acc_r[63:32];
  assign unused_acc_hi_s = acc_r[65:64];

  // Multiplier next-state: IDLE -> BUSY (32 cycles) -> DONE (held while stalled).
  always_comb begin
    mul_state_nxt_s = mul_state_r;
    case (mul_state_r)
      MUL_IDLE: mul_state_nxt_s = mul_start_s ? MUL_BUSY : MUL_IDLE;
      MUL_BUSY: mul_state_nxt_s = (count_r == 5'd31) ? MUL_DONE : MUL_BUSY;
      MUL_DONE: mul_state_nxt_s = stall_in ? MUL_DONE : MUL_IDLE;
      default:  mul_state_nxt_s = MUL_IDLE;
    endcase
  end

  // Multiplier state register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mul_state_r <= MUL_IDLE;
    end else begin
      mul_state_r <= mul_state_nxt_s;
    end
  end

  // Shift-add datapath. Only the low 32 multiplier bits are iterated; a negative
  // signed rs2 is handled by pre-loading the accumulator with -(A << 32).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_r    <= 66'd0;
      mcand_r  <= 66'd0;
      mplier_r <= 32'd0;
      count_r  <= 5'd0;
    end else if (mul_start_s) begin
      mcand_r  <= mcand_init_s;
      mplier_r <= fwd_rs2_s;
      count_r  <= 5'd0;
      acc_r    <= (mul_b_signed_s & fwd_rs2_s[31]) ? (66'd0 - (mcand_init_s << 32)) : 66'd0;
    end else if (mul_state_r == MUL_BUSY) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      count_r  <= count_r + 5'd1;
    end
  end
`else
  assign ex_busy_s = 1'b0;
  assign mul_res_s = {BIT_W{1'b0}};
`endif

  // EX/MEM register: stall holds, busy or bubble inserts a NOP, else load.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      alu_result_out <= {BIT_W{1'b0}};
      mem_wdata_out  <= {BIT_W{1'b0}};
      PC_plus_4_out  <= {BIT_W{1'b0}};
      rd_out         <= 5'd0;
      memrd_out      <= 1'b0;
      memwr_out      <= 1'b0;
      mem2reg_out    <= 1'b0;
      regwr_out      <= 1'b0;
    end else if (!stall_in) begin
      if (ex_busy_s || !valid_in) begin
        alu_result_out <= {BIT_W{1'b0}};
        mem_wdata_out  <= {BIT_W{1'b0}};
        PC_plus_4_out  <= {BIT_W{1'b0}};
        rd_out         <= 5'd0;
        memrd_out      <= 1'b0;
        memwr_out      <= 1'b0;
        mem2reg_out    <= 1'b0;
        regwr_out      <= 1'b0;
      end else begin
        alu_result_out <= result_s;
        mem_wdata_out  <= fwd_rs2_s;
        PC_plus_4_out  <= pc_in + 32'd4;
        rd_out         <= rd_in;
        memrd_out      <= memrd_in;
        memwr_out      <= memwr_in;
        mem2reg_out    <= mem2reg_in;
        regwr_out      <= regwr_in;
      end
    end
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I core; sits between the ID/EX register and the memory stage.
- Resolves operand forwarding, runs the ALU, and resolves branches and jumps toward IF.
- Owns and drives the EX/MEM pipeline register that feeds the memory stage (alu result, store data, memrd/memwr, PC+4, rd, mem2reg, regwr).
- Optionally contains a multi-cycle iterative multiplier that stalls upstream while busy.

Parameters:
- BIT_W, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-high (asserted = 1); port name per codebase convention.
- valid_in  input  1  ID/EX holds a real instruction; 0 = bubble.
- pc_in  input  BIT_W  instruction PC.
- rs1_data_in, rs2_data_in  input  BIT_W  register-file read data.
- imm_in  input  BIT_W  sign-extended immediate.
- rs1_in, rs2_in, rd_in  input  5  register indices.
- alu_op_in  input  4  operation code:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
  - 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 reserved (result 0).
- alu_src_pc_in, alu_src_imm_in  input  1  select operand A = pc, operand B = imm.
- branch_in, jal_in, jalr_in  input  1  control-flow type.
- funct3_in  input  3  branch condition.
- memrd_in, memwr_in, mem2reg_in, regwr_in  input  1  downstream control.
- wb_regwr_in  input  1  writeback-stage write enable (forwarding source).
- wb_rd_in  input  5  writeback-stage destination (forwarding source).
- wb_data_in  input  BIT_W  writeback-stage data (forwarding source).
- stall_in  input  1  memory stage stalled (DCACHE stall); hold EX/MEM.
- ex_busy  output  1  multiplier occupying EX; hazard unit freezes IF/ID/ID-EX.
- branch_taken  output  1  redirect fetch; combinational.
- branch_target  output  BIT_W  redirect address; combinational.
- alu_result_out, mem_wdata_out, PC_plus_4_out  output  BIT_W  EX/MEM register.
- rd_out  output  5  EX/MEM register.
- memrd_out, memwr_out, mem2reg_out, regwr_out  output  1  EX/MEM register.

Behaviour:
- Reset: every registered output is 0; multiplier FSM returns to IDLE, including when reset arrives mid-operation.
- Forwarding for rs1 and rs2, independently:
  - Index 0 is never forwarded.
  - First priority: EX/MEM register, when regwr_out=1 and rd_out matches the source index.
  - Second priority: WB inputs, when wb_regwr_in=1 and wb_rd_in matches.
  - Otherwise: register-file data.
  - Load-use hazards are removed upstream by the hazard unit; EX/MEM forwarding never sees load data.
- Operand selection:
  - A = alu_src_pc_in ? pc_in : fwd_rs1.
  - B = alu_src_imm_in ? imm_in : fwd_rs2.
  - Shift amount = B[4:0]. SLT compares signed, SLTU unsigned. All results are mod 2^32.
- Jumps: for jal or jalr, the stored result is pc_in+4 regardless of alu_op_in.
- Store data: mem_wdata_out = fwd_rs2, stored unswapped; the memory stage handles byte order.
- Branch resolution: branch_taken = valid_in & !stall_in & !ex_busy & (jal | jalr | (branch & cond)).
  - cond by funct3_in: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU, other values = 0.
  - Comparison uses the forwarded rs1 and rs2.
  - target = jalr ? (fwd_rs1+imm) & ~1 : pc_in+imm.
- EX/MEM update priority, evaluated each rising edge:
  - stall_in = 1: hold every register.
  - else ex_busy = 1: load a bubble (memrd/memwr/mem2reg/regwr = 0, rd = 0; data fields don't-care, driven 0).
  - else valid_in = 0: load a bubble.
  - else: load new values.
- stall_in does not by itself assert ex_busy; the hazard unit combines the two.

Optional Feature:
- Macro: RV32M_MUL_EN.
- Defined: shift-add multiplier with a 66-bit accumulator and FSM IDLE -> BUSY -> DONE.
  - IDLE: valid_in & alu_op 11..14 latches forwarded operands with sign extension per op, count=0, goes to BUSY.
  - BUSY: runs exactly 32 cycles.
  - DONE: result selected (MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits) and loaded into EX/MEM like a normal op.
  - DONE is held while stall_in=1, then returns to IDLE.
  - ex_busy = (IDLE & mul op & valid_in) | BUSY, giving 33 busy cycles per multiply.
- Undefined: no FSM; ex_busy tied 0; ops 11..14 yield result 0 with single-cycle timing.

Test Plan:
- ADD x3 then ADD x4,x3,x3 back-to-back, x3 = 5 -> second instruction's alu_result_out = 10 via EX/MEM forward; WB forward also checked with one bubble between.
- Forward attempt to x0: rd_out=0, regwr_out=1, rs1=0, rs1_data_in=0 -> operand A = 0, not the forwarded value.
- BNE with rs1=7, rs2=8, pc=0x100, imm=-16 -> branch_taken=1, target=0xF0; JALR rs1=0x203, imm=0 -> target 0x202, alu_result_out = pc+4.
- stall_in held 3 cycles during a store -> all EX/MEM outputs stable for 3 cycles, then update on the first cycle after release.
- RV32M_MUL_EN, MULH with -3 and 5 -> ex_busy high exactly 33 cycles, alu_result_out = 0xFFFFFFFF; MUL gives 0xFFFFFFF1.
- rst_n asserted at BUSY cycle 10 -> next edge all outputs 0, ex_busy 0; a new MUL starts cleanly afterward.
